// File: rtl/ovi_store_drain.sv
// Store drain buffer: FIFOs VPU store beats and drains them to a memory write port
// at sequential 64-byte addresses. Optional macro OVI_STORE_OVERFLOW_CHK_EN adds err_overflow_o.
module ovi_store_drain #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 40,
  parameter int SB_W   = 5
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              op_start_i,
  input  logic [SB_W-1:0]   op_sb_id_i,
  input  logic [ADDR_W-1:0] op_base_i,
  input  logic [7:0]        op_beats_i,
  input  logic              store_valid_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              store_credit_o,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ready_i,
  output logic              sync_end_o,
  output logic [SB_W-1:0]   sync_end_sb_id_o,
`ifdef OVI_STORE_OVERFLOW_CHK_EN
  output logic              err_overflow_o,
`endif
  output logic              busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         rem_q, rem_d;
  logic [SB_W-1:0]    sb_q, sb_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               credit_q;
  logic [DATA_W-1:0]  fifo_q [DEPTH];

  logic empty_s, full_s, push_s, pop_s, active_s;

  assign active_s = (state_q == S_ACTIVE);
  assign empty_s  = (count_q == CNT_W'(0));
  assign full_s   = (count_q == CNT_W'(DEPTH));
  assign pop_s    = active_s && !empty_s && mem_ready_i;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push_s   = store_valid_i && (!full_s || pop_s);

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and credit return
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      credit_q <= pop_s;
    end
  end

  // FIFO storage; contents are only observed through the gated head
  always_ff @(posedge clk_i) begin
    if (push_s) fifo_q[wr_ptr_q] <= store_data_i;
  end

  // Memop FSM next-state and address/remaining bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sb_d    = sb_q;
    case (state_q)
      S_IDLE: begin
        if (op_start_i) begin
          sb_d    = op_sb_id_i;
          addr_d  = op_base_i;
          rem_d   = op_beats_i;
          state_d = (op_beats_i == 8'd0) ? S_DONE : S_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (pop_s) begin
          addr_d  = addr_q + ADDR_W'(64);
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? S_DONE : S_ACTIVE;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= 8'd0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sb_q    <= sb_d;
    end
  end

`ifdef OVI_STORE_OVERFLOW_CHK_EN
  logic err_q;

  // Sticky overflow flag on a dropped beat
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      err_q <= 1'b0;
    end else if (store_valid_i && full_s && !pop_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err_overflow_o = err_q;
`endif

  // Outputs are decoded purely from registers so they hold while the request stalls.
  assign mem_valid_o      = active_s && !empty_s;
  assign mem_addr_o       = addr_q;
  assign mem_data_o       = mem_valid_o ? fifo_q[rd_ptr_q] : '0;
  assign store_credit_o   = credit_q;
  assign sync_end_o       = (state_q == S_DONE);
  assign sync_end_sb_id_o = (state_q == S_DONE) ? sb_q : '0;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ovi_store_drain.sv
// Directed self-checking bench for ovi_store_drain (default DEPTH=4 configuration).
module tb_ovi_store_drain;

  localparam int DW = 512;
  localparam int AW = 40;
  localparam int SW = 5;

  logic          clk_i = 1'b0;
  logic          rsn_i;
  logic          op_start_i;
  logic [SW-1:0] op_sb_id_i;
  logic [AW-1:0] op_base_i;
  logic [7:0]    op_beats_i;
  logic          store_valid_i;
  logic [DW-1:0] store_data_i;
  logic          store_credit_o;
  logic          mem_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ready_i;
  logic          sync_end_o;
  logic [SW-1:0] sync_end_sb_id_o;
  logic          busy_o;
`ifdef OVI_STORE_OVERFLOW_CHK_EN
  logic          err_overflow_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ovi_store_drain dut (
    .clk_i            (clk_i),
    .rsn_i            (rsn_i),
    .op_start_i       (op_start_i),
    .op_sb_id_i       (op_sb_id_i),
    .op_base_i        (op_base_i),
    .op_beats_i       (op_beats_i),
    .store_valid_i    (store_valid_i),
    .store_data_i     (store_data_i),
    .store_credit_o   (store_credit_o),
    .mem_valid_o      (mem_valid_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .mem_ready_i      (mem_ready_i),
    .sync_end_o       (sync_end_o),
    .sync_end_sb_id_o (sync_end_sb_id_o),
`ifdef OVI_STORE_OVERFLOW_CHK_EN
    .err_overflow_o   (err_overflow_o),
`endif
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] beat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + i[31:0];
    return {16{w}};
  endfunction

  task automatic start_op(input logic [SW-1:0] sb, input logic [AW-1:0] base, input logic [7:0] n);
    op_start_i = 1'b1;
    op_sb_id_i = sb;
    op_base_i  = base;
    op_beats_i = n;
    step();
    op_start_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_credit"}, DW'(store_credit_o), DW'(1'b0));
    check_eq({tag, "_mvalid"}, DW'(mem_valid_o), DW'(1'b0));
    check_eq({tag, "_maddr"}, DW'(mem_addr_o), DW'(0));
    check_eq({tag, "_mdata"}, mem_data_o, DW'(0));
    check_eq({tag, "_sync"}, DW'(sync_end_o), DW'(1'b0));
    check_eq({tag, "_sbid"}, DW'(sync_end_sb_id_o), DW'(0));
    check_eq({tag, "_busy"}, DW'(busy_o), DW'(1'b0));
  endtask

  initial begin
    rsn_i = 1'b0; op_start_i = 1'b0; op_sb_id_i = '0; op_base_i = '0; op_beats_i = 8'd0;
    store_valid_i = 1'b0; store_data_i = '0; mem_ready_i = 1'b0;
    step(); step();
    check_idle_outputs("rst");
`ifdef OVI_STORE_OVERFLOW_CHK_EN
    check_eq("rst_err", DW'(err_overflow_o), DW'(1'b0));
`endif
    rsn_i = 1'b1;
    step();

    // Single beat
    start_op(5'd3, 40'h10_00, 8'd1);
    store_valid_i = 1'b1; store_data_i = {64{8'hA5}}; mem_ready_i = 1'b1;
    step();
    store_valid_i = 1'b0;
    check_eq("sb_valid", DW'(mem_valid_o), DW'(1'b1));
    check_eq("sb_addr", DW'(mem_addr_o), DW'(40'h10_00));
    check_eq("sb_data", mem_data_o, {64{8'hA5}});
    check_eq("sb_credit0", DW'(store_credit_o), DW'(1'b0));
    step();
    check_eq("sb_credit1", DW'(store_credit_o), DW'(1'b1));
    check_eq("sb_sync", DW'(sync_end_o), DW'(1'b1));
    check_eq("sb_id", DW'(sync_end_sb_id_o), DW'(5'd3));
    check_eq("sb_valid_done", DW'(mem_valid_o), DW'(1'b0));
    step();
    check_eq("sb_sync_off", DW'(sync_end_o), DW'(1'b0));
    check_eq("sb_busy_off", DW'(busy_o), DW'(1'b0));
    check_eq("sb_credit_off", DW'(store_credit_o), DW'(1'b0));
    mem_ready_i = 1'b0;

    // Backpressure: four beats held, then drained
    start_op(5'd1, 40'h10_00, 8'd4);
    for (int i = 0; i < 4; i++) begin
      store_valid_i = 1'b1; store_data_i = beat(i);
      step();
    end
    store_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_valid", DW'(mem_valid_o), DW'(1'b1));
      check_eq("bp_hold_addr", DW'(mem_addr_o), DW'(40'h10_00));
      check_eq("bp_hold_data", mem_data_o, beat(0));
      step();
    end
    mem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_addr", DW'(mem_addr_o), DW'(40'h10_00 + 40'(64 * i)));
      check_eq("bp_data", mem_data_o, beat(i));
      step();
      check_eq("bp_credit", DW'(store_credit_o), DW'(1'b1));
    end
    check_eq("bp_sync", DW'(sync_end_o), DW'(1'b1));
    check_eq("bp_id", DW'(sync_end_sb_id_o), DW'(5'd1));
    mem_ready_i = 1'b0;
    step();

    // Full and overflow: five beats while idle, fifth dropped
    for (int i = 0; i < 5; i++) begin
      store_valid_i = 1'b1; store_data_i = beat(10 + i);
      step();
    end
    store_valid_i = 1'b0;
    check_eq("ov_idle_valid", DW'(mem_valid_o), DW'(1'b0));
`ifdef OVI_STORE_OVERFLOW_CHK_EN
    check_eq("ov_err", DW'(err_overflow_o), DW'(1'b1));
`endif
    start_op(5'd2, 40'h20_00, 8'd5);
    store_valid_i = 1'b1; store_data_i = beat(99); mem_ready_i = 1'b1;
    check_eq("ov_data0", mem_data_o, beat(10));
    step();
    store_valid_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check_eq("ov_data", mem_data_o, beat(10 + i));
      step();
    end
    check_eq("ov_data_new", mem_data_o, beat(99));
    check_eq("ov_addr_new", DW'(mem_addr_o), DW'(40'h20_00 + 40'd256));
    step();
    check_eq("ov_sync", DW'(sync_end_o), DW'(1'b1));
    check_eq("ov_id", DW'(sync_end_sb_id_o), DW'(5'd2));
    step();
    check_eq("ov_empty", DW'(mem_valid_o), DW'(1'b0));

    // Zero-length memop
    start_op(5'd7, 40'h30_00, 8'd0);
    check_eq("z_sync", DW'(sync_end_o), DW'(1'b1));
    check_eq("z_id", DW'(sync_end_sb_id_o), DW'(5'd7));
    check_eq("z_valid", DW'(mem_valid_o), DW'(1'b0));
    step();
    check_eq("z_idle", DW'(busy_o), DW'(1'b0));

    // Start during ACTIVE is ignored
    start_op(5'd4, 40'h30_00, 8'd1);
    start_op(5'd9, 40'h50_00, 8'd0);
    check_eq("ig_busy", DW'(busy_o), DW'(1'b1));
    check_eq("ig_sync", DW'(sync_end_o), DW'(1'b0));
    store_valid_i = 1'b1; store_data_i = beat(20);
    step();
    store_valid_i = 1'b0;
    check_eq("ig_addr", DW'(mem_addr_o), DW'(40'h30_00));
    step();
    check_eq("ig_sync_end", DW'(sync_end_o), DW'(1'b1));
    check_eq("ig_id", DW'(sync_end_sb_id_o), DW'(5'd4));
    step();

    // Address wrap
    start_op(5'd5, 40'hFF_FFFF_FFC0, 8'd2);
    store_valid_i = 1'b1; store_data_i = beat(30);
    step();
    store_data_i = beat(31);
    check_eq("wr_addr0", DW'(mem_addr_o), DW'(40'hFF_FFFF_FFC0));
    step();
    store_valid_i = 1'b0;
    check_eq("wr_addr1", DW'(mem_addr_o), DW'(40'h0));
    check_eq("wr_data1", mem_data_o, beat(31));
    step();
    check_eq("wr_sync", DW'(sync_end_o), DW'(1'b1));
    mem_ready_i = 1'b0;
    step();

    // Reset mid-op after two of four beats
    start_op(5'd6, 40'h40_00, 8'd4);
    for (int i = 0; i < 4; i++) begin
      store_valid_i = 1'b1; store_data_i = beat(40 + i);
      step();
    end
    store_valid_i = 1'b0; mem_ready_i = 1'b1;
    check_eq("rm_addr0", DW'(mem_addr_o), DW'(40'h40_00));
    step();
    check_eq("rm_data1", mem_data_o, beat(41));
    step();
    rsn_i = 1'b0;
    #1;
    check_idle_outputs("rm_rst");
    step();
    check_eq("rm_nosync", DW'(sync_end_o), DW'(1'b0));
    rsn_i = 1'b1;
    step();
    start_op(5'd8, 40'h60_00, 8'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("rm_empty", DW'(mem_valid_o), DW'(1'b0));
      step();
    end
    check_eq("rm_nosync2", DW'(sync_end_o), DW'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
